// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the sync generator and the
// pattern/render blocks that consume its counters.
package vga_timing_pkg;

    localparam int CNT_W   = 10;

    localparam int HPIXELS = 800;
    localparam int VLINES  = 521;
    localparam int HPULSE  = 96;
    localparam int VPULSE  = 2;
    localparam int HBP     = 144;
    localparam int HFP     = 784;
    localparam int VBP     = 31;
    localparam int VFP     = 511;

    typedef logic [CNT_W-1:0] cnt_t;

    // Half-open window test: lo <= v < hi.
    function automatic logic in_range(input cnt_t v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate clock enable: divides i_clk by CLK_DIV and pulses o_pix_en on the
// last system clock of every pixel period.
module vga_pix_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_pix_en
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign o_pix_en = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel counters, active-low syncs, active-video flag and
// frame-start pulse. Define VGA_FRAME_CNT_EN to add the 16-bit o_frame_cnt output.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int hpixels = HPIXELS,
    parameter int vlines  = VLINES,
    parameter int hpulse  = HPULSE,
    parameter int vpulse  = VPULSE,
    parameter int hbp     = HBP,
    parameter int hfp     = HFP,
    parameter int vbp     = VBP,
    parameter int vfp     = VFP,
    parameter int CLK_DIV = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_pix_en,
    output logic [CNT_W-1:0] o_hc,
    output logic [CNT_W-1:0] o_vc,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_active,
    output logic             o_frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      o_frame_cnt
`endif
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(hpixels - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(vlines - 1);

    logic             line_end;
    logic             frame_end;
    logic [CNT_W-1:0] hc_next;
    logic [CNT_W-1:0] vc_next;

    vga_pix_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .o_pix_en (o_pix_en)
    );

    // Next counter position; equals the current one between pixel enables.
    always_comb begin
        line_end  = (o_hc == H_LAST);
        frame_end = line_end && (o_vc == V_LAST);
        hc_next   = o_hc;
        vc_next   = o_vc;
        if (o_pix_en) begin
            if (line_end) begin
                hc_next = '0;
                vc_next = (o_vc == V_LAST) ? '0 : o_vc + 1'b1;
            end else begin
                hc_next = o_hc + 1'b1;
            end
        end
    end

    // Decode syncs from the next position so they land on the same edge as the counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hc          <= '0;
            o_vc          <= '0;
            o_hsync       <= 1'b0;
            o_vsync       <= 1'b0;
            o_active      <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_hc     <= hc_next;
            o_vc     <= vc_next;
            o_hsync  <= !in_range(hc_next, 0, hpulse);
            o_vsync  <= !in_range(vc_next, 0, vpulse);
            o_active <= in_range(hc_next, hbp, hfp) && in_range(vc_next, vbp, vfp);
            if (o_pix_en) begin
                o_frame_start <= frame_end;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_d;

    assign frame_cnt_d = (o_pix_en && frame_end) ? o_frame_cnt + 16'd1 : o_frame_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_frame_cnt <= '0;
        end else begin
            o_frame_cnt <= frame_cnt_d;
        end
    end
`endif

endmodule
